mem_port_arbiter: RTL and testbench

//  Shares one single-port, fixed-latency unified memory between the fetch stage (instruction reads)
//  and the memory stage (data loads/stores) of the 5-stage pipeline. Sequences each access:

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter_lat_counter.sv | 36 +++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
// Imported by the counter, the arbiter top and the bench.
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_e;

    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status signals of the memory port arbiter.
// slave = arbiter view, master = pipeline/memory view.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          halt;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          dm_rd;
    logic          dm_wr;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall_if;
    logic          stall_mem;
    logic          err;

    modport slave (
        input  halt, if_req, if_addr,
        input  dm_rd, dm_wr, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_rdata, if_done,
        output dm_rdata, dm_done,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output stall_if, stall_mem, err
    );

    modport master (
        output halt, if_req, if_addr,
        output dm_rd, dm_wr, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_rdata, if_done,
        input  dm_rdata, dm_done,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  stall_if, stall_mem, err
    );
endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter timing the memory latency wait.
module mem_lat_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] value,
    output logic             zero,
    output logic             one
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign zero = (cnt_q == '0);
    assign one  = (cnt_q == CNT_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (dec && !zero) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the shared fixed-latency memory port.
// MEM_ARB_ALIGN_ERR_EN: flag odd addresses and force addr[0]=0.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 4,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_e    state_q, state_d;
    owner_e        owner_q, owner_d;
    owner_e        last_q, last_d;
    logic          wr_q, wr_d;
    logic          en_q, en_d;
    logic          err_q, err_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          cnt_load, cnt_dec;
    logic          cnt_zero, cnt_one;
    logic          dm_pend, pick_data;

    mem_lat_counter u_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .value (lat_load(MEM_LAT)),
        .zero  (cnt_zero),
        .one   (cnt_one)
    );

    assign dm_pend = bus.dm_rd || bus.dm_wr;
    // Data wins unless fetch is also waiting and data had the last turn.
    assign pick_data = dm_pend &&
                       !(bus.if_req && last_q == DATA);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        wr_d       = wr_q;
        en_d       = 1'b0;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bus.halt && (dm_pend || bus.if_req)) begin
                    state_d = ISSUE;
                    en_d    = 1'b1;
                    owner_d = pick_data ? DATA : FETCH;
                    last_d  = pick_data ? DATA : FETCH;
                    wr_d    = pick_data && bus.dm_wr;
                    addr_d  = pick_data ? bus.dm_addr : bus.if_addr;
                    if (pick_data) begin
                        wdata_d = bus.dm_wdata;
                    end
                    if (pick_data && bus.dm_rd && bus.dm_wr) begin
                        err_d = 1'b1;
                    end
`ifdef MEM_ARB_ALIGN_ERR_EN
                    if (addr_d[0]) begin
                        err_d     = 1'b1;
                        addr_d[0] = 1'b0;
                    end
`endif
                end
            end
            ISSUE: begin
                cnt_load = 1'b1;
                state_d  = (MEM_LAT == 1) ? DONE : WAIT;
            end
            WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_one || cnt_zero) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!wr_q && owner_q == DATA) begin
                    dm_rdata_d = bus.mem_rdata;
                end
                if (!wr_q && owner_q == FETCH) begin
                    if_rdata_d = bus.mem_rdata;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= FETCH;
            last_q     <= FETCH;
            wr_q       <= 1'b0;
            en_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            wr_q       <= wr_d;
            en_q       <= en_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // Read data is forwarded in the DONE cycle, then held.
    assign bus.if_done  = (state_q == DONE) && (owner_q == FETCH);
    assign bus.dm_done  = (state_q == DONE) && (owner_q == DATA);
    assign bus.if_rdata = (bus.if_done && !wr_q) ? bus.mem_rdata
                                                 : if_rdata_q;
    assign bus.dm_rdata = (bus.dm_done && !wr_q) ? bus.mem_rdata
                                                 : dm_rdata_q;

    assign bus.mem_en    = en_q;
    assign bus.mem_wr    = wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.err       = err_q;

    assign bus.stall_if  = bus.if_req && !bus.if_done;
    assign bus.stall_mem = dm_pend && !bus.dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus hand sequences.
module tb_mem_port_arbiter;

    localparam int L = 4;
`ifdef MEM_ARB_ALIGN_ERR_EN
    localparam logic ALIGN = 1'b1;
`else
    localparam logic ALIGN = 1'b0;
`endif

    typedef struct packed {
        logic        ifr;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        exp_wr;
        logic [15:0] exp_addr;
        logic [15:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    mem_port_arbiter_if #(.AW(16), .DW(16)) bus ();

    mem_port_arbiter #(.MEM_LAT(L), .AW(16), .DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model: fixed contents, read data valid L cycles after mem_en.
    function automatic logic [15:0] rd_val(input logic [15:0] a);
        return (a == 16'h0010) ? 16'h1234 : (a ^ 16'h5A00);
    endfunction

    logic [15:0] pipe [L];
    assign bus.mem_rdata = pipe[L-1];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < L; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= (bus.mem_en && !bus.mem_wr) ?
                       rd_val(bus.mem_addr) : 16'hDEAD;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int          en_at, done_at;
        logic [15:0] a, wd, rdv;
        logic        w, st, other;
        en_at = -1; done_at = -1;
        a = '0; wd = '0; rdv = '0; w = 1'b0; st = 1'b0; other = 1'b0;
        bus.if_req   = v.ifr;
        bus.if_addr  = v.addr;
        bus.dm_rd    = v.rd;
        bus.dm_wr    = v.wr;
        bus.dm_addr  = v.addr;
        bus.dm_wdata = v.wdata;
        for (int k = 0; k < 40 && done_at < 0; k++) begin
            @(negedge clk);
            if (k == 0) st = v.ifr ? bus.stall_if : bus.stall_mem;
            if (bus.mem_en && en_at < 0) begin
                en_at = k;
                a     = bus.mem_addr;
                w     = bus.mem_wr;
                wd    = bus.mem_wdata;
            end
            if (v.ifr ? bus.if_done : bus.dm_done) begin
                done_at = k;
                rdv     = v.ifr ? bus.if_rdata : bus.dm_rdata;
                other   = v.ifr ? bus.dm_done : bus.if_done;
            end
        end
        bus.if_req = 1'b0;
        bus.dm_rd  = 1'b0;
        bus.dm_wr  = 1'b0;
        check({nm, "_stall"}, st, 1);
        check({nm, "_en_cycle"}, en_at, 1);
        check({nm, "_done_cycle"}, done_at, 1 + L);
        check({nm, "_mem_addr"}, a, v.exp_addr);
        check({nm, "_mem_wr"}, w, v.exp_wr);
        if (v.wr) check({nm, "_mem_wdata"}, wd, v.wdata);
        check({nm, "_rdata"}, rdv, v.exp_rdata);
        check({nm, "_other_done"}, other, 0);
        @(posedge clk); #1;
    endtask

    logic [15:0] gr [4];
    int          ngr, if_k, dm_k;
    logic        stall_ok;

    task automatic run_seq(input logic start_if, input int n_dm);
        int left;
        left = n_dm; ngr = 0; if_k = -1; dm_k = -1; stall_ok = 1'b1;
        for (int i = 0; i < 4; i++) gr[i] = '0;
        bus.dm_rd   = 1'b1;
        bus.dm_wr   = 1'b0;
        bus.dm_addr = 16'h0060;
        bus.if_req  = start_if;
        bus.if_addr = 16'h0070;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus.mem_en && ngr < 4) begin
                gr[ngr] = bus.mem_addr;
                ngr++;
            end
            if (bus.if_req && !bus.if_done && !bus.stall_if) stall_ok = 1'b0;
            if (bus.if_done) begin
                if_k = k;
                bus.if_req = 1'b0;
            end
            if (bus.dm_done) begin
                dm_k = k;
                left--;
                if (left > 0) begin
                    bus.dm_addr = 16'h0062;
                    bus.if_req  = 1'b1;
                end else begin
                    bus.dm_rd = 1'b0;
                end
            end
            if (!bus.if_req && !bus.dm_rd) break;
        end
        check("seq_drained", {bus.if_req, bus.dm_rd}, 2'b00);
        bus.if_req = 1'b0;
        bus.dm_rd  = 1'b0;
        @(posedge clk); #1;
    endtask

    vec_t tbl [6];

    initial begin
        int          n, done_k;
        logic [15:0] rdv;
        vec_t        v;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000,
                   1'b0, 16'h0010, 16'h1234};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000,
                   1'b0, 16'h0020, 16'h5A20};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 16'h0040, 16'hBEEF,
                   1'b1, 16'h0040, 16'h5A20};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000,
                   1'b0, 16'h0100, 16'h5B00};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 16'h0ABC, 16'h0000,
                   1'b0, 16'h0ABC, 16'h50BC};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 16'h0012, 16'h0000,
                   1'b0, 16'h0012, 16'h5A12};

        bus.halt = 1'b0; bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
        bus.dm_addr = '0; bus.dm_wdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_mem_wr", bus.mem_wr, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_dones", {bus.if_done, bus.dm_done}, 0);
        check("rst_if_rdata", bus.if_rdata, 0);
        check("rst_dm_rdata", bus.dm_rdata, 0);
        check("rst_err", bus.err, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end
        check("err_clean", bus.err, 0);

        // both raised together, fetch had the last turn
        run_seq(1'b1, 1);
        check("A_ngrants", ngr, 2);
        check("A_grant0", gr[0], 16'h0060);
        check("A_grant1", gr[1], 16'h0070);
        check("A_dm_done_k", dm_k, 1 + L);
        check("A_if_done_k", if_k, 2 * L + 3);
        check("A_stall_if", stall_ok, 1);
        check("A_dm_rdata_hold", bus.dm_rdata, 16'h5A60);
        check("A_if_rdata_hold", bus.if_rdata, 16'h5A70);

        // data, then both pending: fetch first, then data
        run_seq(1'b0, 2);
        check("B_ngrants", ngr, 3);
        check("B_grant0", gr[0], 16'h0060);
        check("B_grant1", gr[1], 16'h0070);
        check("B_grant2", gr[2], 16'h0062);
        check("B_if_done_k", if_k, 2 * L + 3);
        check("B_dm_done_k", dm_k, 3 * L + 5);
        check("B_dm_rdata", bus.dm_rdata, 16'h5A62);

        // reset during WAIT
        bus.if_req = 1'b1; bus.if_addr = 16'h0010;
        @(negedge clk);
        @(negedge clk);
        check("R_issue_en", bus.mem_en, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("R_mem_en", bus.mem_en, 0);
        check("R_mem_addr", bus.mem_addr, 0);
        check("R_if_done", bus.if_done, 0);
        check("R_if_rdata", bus.if_rdata, 0);
        check("R_dm_rdata", bus.dm_rdata, 0);
        bus.if_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.if_done || bus.dm_done || bus.mem_en) n++;
        end
        check("R_no_done", n, 0);
        @(posedge clk); #1;
        run_vec(tbl[0], "R_fresh");

        // halt with fetch pending in IDLE
        bus.halt = 1'b1; bus.if_req = 1'b1; bus.if_addr = 16'h0010;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.mem_en) n++;
        end
        check("H_no_grant", n, 0);
        check("H_stall_if", bus.stall_if, 1);
        bus.if_req = 1'b0;
        @(posedge clk); #1;
        bus.halt = 1'b0;

        // halt raised mid-access
        bus.if_req = 1'b1; bus.if_addr = 16'h0020;
        done_k = -1; rdv = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 2) bus.halt = 1'b1;
            if (bus.if_done) begin
                done_k = k;
                rdv = bus.if_rdata;
                bus.if_req = 1'b0;
                break;
            end
        end
        check("HM_done_k", done_k, 1 + L);
        check("HM_rdata", rdv, 16'h5A20);
        bus.dm_rd = 1'b1; bus.dm_addr = 16'h0030;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.mem_en) n++;
        end
        check("HM_blocked", n, 0);
        bus.dm_rd = 1'b0;
        @(posedge clk); #1;
        bus.halt = 1'b0;
        v = '{1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000,
              1'b0, 16'h0030, 16'h5A30};
        run_vec(v, "HM_after");

        // odd address load
        v = '{1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0,
              ALIGN ? 16'h0002 : 16'h0003,
              ALIGN ? 16'h5A02 : 16'h5A03};
        run_vec(v, "odd");
        check("odd_err", bus.err, ALIGN);

        // load and store together: store, sticky err
        v = '{1'b0, 1'b1, 1'b1, 16'h0044, 16'h1111, 1'b1, 16'h0044,
              ALIGN ? 16'h5A02 : 16'h5A03};
        run_vec(v, "rdwr");
        check("rdwr_err", bus.err, 1);
        repeat (3) @(negedge clk);
        check("err_sticky", bus.err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
